// File: rtl/fft_pkg.sv
// Shared definitions for the FFT datapath scaling blocks.
package fft_pkg;

  localparam int DEF_DATA_WIDTH  = 16;
  localparam int DEF_OUT_WIDTH   = 32;
  localparam int DEF_SHIFT_WIDTH = 4;
  localparam int DEF_ROUND       = 1;

  typedef enum logic {
    SHIFT_LEFT  = 1'b0,
    SHIFT_RIGHT = 1'b1
  } shift_dir_e;

  // One bit of a signed saturation bound of out_width bits.
  // neg=1 selects -2^(out_width-1), neg=0 selects 2^(out_width-1)-1.
  // Working bit by bit keeps the bound exactly as wide as the caller's lane.
  function automatic logic sat_bound_bit(input logic neg, input int out_width, input int idx);
    if (idx == out_width - 1) begin
      return neg;
    end
    return ~neg;
  endfunction

endpackage

// File: rtl/shift_sat_lane.sv
// Combinational shift, optional round-half-up and saturation for one lane.
module shift_sat_lane
  import fft_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int OUT_WIDTH   = DEF_OUT_WIDTH,
  parameter int SHIFT_WIDTH = DEF_SHIFT_WIDTH,
  parameter int ROUND       = DEF_ROUND
) (
  input  logic signed [DATA_WIDTH-1:0]  x,
  input  logic        [SHIFT_WIDTH-1:0] amt,
  input  shift_dir_e                    dir,
  output logic signed [OUT_WIDTH-1:0]   y,
  output logic                          ovf
);

  // Working width is generous enough that no left shift or rounding add can
  // wrap, so the sign bit of the wide result is always the true sign.
  localparam int WW = OUT_WIDTH + (1 << SHIFT_WIDTH) + 1;

  logic signed [WW-1:0]           ext;
  logic signed [WW-1:0]           bias;
  logic signed [WW-1:0]           shifted;
  logic        [WW-OUT_WIDTH:0]   upper;

  // Shift, round, then clamp to the output range if the top bits are not a pure sign extension.
  always_comb begin
    ext  = {{(WW-DATA_WIDTH){x[DATA_WIDTH-1]}}, x};
    bias = '0;
    if ((ROUND != 0) && (amt != '0)) begin
      bias = WW'(1) <<< (amt - SHIFT_WIDTH'(1));
    end
    if (dir == SHIFT_RIGHT) begin
      shifted = (ext + bias) >>> amt;
    end else begin
      shifted = ext <<< amt;
    end
    upper = shifted[WW-1:OUT_WIDTH-1];
    ovf   = !((&upper) || !(|upper));
    y     = shifted[OUT_WIDTH-1:0];
    if (ovf) begin
      for (int i = 0; i < OUT_WIDTH; i++) begin
        y[i] = sat_bound_bit(shifted[WW-1], OUT_WIDTH, i);
      end
    end
  end

endmodule

// File: rtl/cplx_scale_shifter.sv
// Two-stage elastic scaling shifter for complex samples with overflow reporting.
module cplx_scale_shifter
  import fft_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int OUT_WIDTH   = DEF_OUT_WIDTH,
  parameter int SHIFT_WIDTH = DEF_SHIFT_WIDTH,
  parameter int ROUND       = DEF_ROUND
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic signed [DATA_WIDTH-1:0]  in_re,
  input  logic signed [DATA_WIDTH-1:0]  in_im,
  input  logic        [SHIFT_WIDTH-1:0] shift_amt,
  input  logic                          shift_dir,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic signed [OUT_WIDTH-1:0]   out_re,
  output logic signed [OUT_WIDTH-1:0]   out_im,
  output logic                          out_ovf,
  output logic                          ovf_sticky,
  input  logic                          ovf_clr
);

  logic                          s1_valid;
  logic signed [DATA_WIDTH-1:0]  s1_re;
  logic signed [DATA_WIDTH-1:0]  s1_im;
  logic        [SHIFT_WIDTH-1:0] s1_amt;
  shift_dir_e                    s1_dir;

  logic                          s1_load;
  logic                          s2_load;
  logic signed [OUT_WIDTH-1:0]   lane_re;
  logic signed [OUT_WIDTH-1:0]   lane_im;
  logic                          ovf_re;
  logic                          ovf_im;

  // S2 takes new content when empty or when its sample leaves this cycle;
  // S1 can accept whenever it is empty or about to move into S2.
  assign s2_load  = !out_valid || out_ready;
  assign in_ready = !s1_valid || s2_load;
  assign s1_load  = in_valid && in_ready;

  shift_sat_lane #(
    .DATA_WIDTH (DATA_WIDTH),
    .OUT_WIDTH  (OUT_WIDTH),
    .SHIFT_WIDTH(SHIFT_WIDTH),
    .ROUND      (ROUND)
  ) u_lane_re (
    .x  (s1_re),
    .amt(s1_amt),
    .dir(s1_dir),
    .y  (lane_re),
    .ovf(ovf_re)
  );

  shift_sat_lane #(
    .DATA_WIDTH (DATA_WIDTH),
    .OUT_WIDTH  (OUT_WIDTH),
    .SHIFT_WIDTH(SHIFT_WIDTH),
    .ROUND      (ROUND)
  ) u_lane_im (
    .x  (s1_im),
    .amt(s1_amt),
    .dir(s1_dir),
    .y  (lane_im),
    .ovf(ovf_im)
  );

  // Stage 1: capture the raw sample together with its own shift control.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_re    <= '0;
      s1_im    <= '0;
      s1_amt   <= '0;
      s1_dir   <= SHIFT_LEFT;
    end else begin
      if (in_ready) begin
        s1_valid <= in_valid;
      end
      if (s1_load) begin
        s1_re  <= in_re;
        s1_im  <= in_im;
        s1_amt <= shift_amt;
        s1_dir <= shift_dir_e'(shift_dir);
      end
    end
  end

  // Stage 2: register the scaled result; everything holds while downstream stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_re    <= '0;
      out_im    <= '0;
      out_ovf   <= 1'b0;
    end else if (s2_load) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_re  <= lane_re;
        out_im  <= lane_im;
        out_ovf <= ovf_re | ovf_im;
      end
    end
  end

  // Sticky overflow: a saturated sample leaving the block takes priority over a clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_sticky <= 1'b0;
    end else if (out_valid && out_ready && out_ovf) begin
      ovf_sticky <= 1'b1;
    end else if (ovf_clr) begin
      ovf_sticky <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cplx_scale_shifter.sv
// Self-checking bench: three instances (rounding, truncating, narrow output) share one stimulus.
module tb_cplx_scale_shifter;
  import fft_pkg::*;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic               out_ready;
  logic               ovf_clr;
  logic signed [15:0] in_re;
  logic signed [15:0] in_im;
  logic        [3:0]  shift_amt;
  logic               shift_dir;

  logic               a_in_ready, a_out_valid, a_ovf, a_sticky;
  logic signed [31:0] a_re, a_im;
  logic               t_in_ready, t_out_valid, t_ovf, t_sticky;
  logic signed [31:0] t_re, t_im;
  logic               s_in_ready, s_out_valid, s_ovf, s_sticky;
  logic signed [15:0] s_re, s_im;

  int checks = 0;
  int failures = 0;

  typedef struct {
    longint re_a, im_a, re_t, im_t, re_s, im_s;
    bit     ovf_a, ovf_t, ovf_s;
  } exp_t;

  exp_t sb[$];
  exp_t head;

  cplx_scale_shifter #(.DATA_WIDTH(16), .OUT_WIDTH(32), .SHIFT_WIDTH(4), .ROUND(1)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_re(in_re), .in_im(in_im), .shift_amt(shift_amt), .shift_dir(shift_dir),
    .out_valid(a_out_valid), .out_ready(out_ready), .out_re(a_re), .out_im(a_im),
    .out_ovf(a_ovf), .ovf_sticky(a_sticky), .ovf_clr(ovf_clr));

  cplx_scale_shifter #(.DATA_WIDTH(16), .OUT_WIDTH(32), .SHIFT_WIDTH(4), .ROUND(0)) dut_t (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(t_in_ready),
    .in_re(in_re), .in_im(in_im), .shift_amt(shift_amt), .shift_dir(shift_dir),
    .out_valid(t_out_valid), .out_ready(out_ready), .out_re(t_re), .out_im(t_im),
    .out_ovf(t_ovf), .ovf_sticky(t_sticky), .ovf_clr(ovf_clr));

  cplx_scale_shifter #(.DATA_WIDTH(16), .OUT_WIDTH(16), .SHIFT_WIDTH(4), .ROUND(1)) dut_s (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_re(in_re), .in_im(in_im), .shift_amt(shift_amt), .shift_dir(shift_dir),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_re(s_re), .out_im(s_im),
    .out_ovf(s_ovf), .ovf_sticky(s_sticky), .ovf_clr(ovf_clr));

  always #5 clk = ~clk;

  // Reference arithmetic on plain integers: shift, optional round-half-up, clamp.
  function automatic longint model(input int ow, input bit rnd, input longint x,
                                   input int amt, input bit dir, output bit ovf);
    longint v, hi, lo;
    if (dir == 1'b0)            v = x * (longint'(1) << amt);
    else if (rnd && amt > 0)    v = (x + (longint'(1) << (amt - 1))) >>> amt;
    else                        v = x >>> amt;
    hi  = (longint'(1) << (ow - 1)) - 1;
    lo  = -hi - 1;
    ovf = 1'b0;
    if (v > hi) begin v = hi; ovf = 1'b1; end
    else if (v < lo) begin v = lo; ovf = 1'b1; end
    return v;
  endfunction

  function automatic exp_t predict(input logic signed [15:0] re, input logic signed [15:0] im,
                                   input logic [3:0] amt, input logic dir);
    exp_t e;
    bit o1, o2;
    e.re_a = model(32, 1'b1, longint'(re), int'(amt), dir, o1);
    e.im_a = model(32, 1'b1, longint'(im), int'(amt), dir, o2);
    e.ovf_a = o1 | o2;
    e.re_t = model(32, 1'b0, longint'(re), int'(amt), dir, o1);
    e.im_t = model(32, 1'b0, longint'(im), int'(amt), dir, o2);
    e.ovf_t = o1 | o2;
    e.re_s = model(16, 1'b1, longint'(re), int'(amt), dir, o1);
    e.im_s = model(16, 1'b1, longint'(im), int'(amt), dir, o2);
    e.ovf_s = o1 | o2;
    return e;
  endfunction

  task automatic checkOutput(input string tag, input logic signed [63:0] observed,
                             input logic signed [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Scoreboard: push on input transfer, pop and compare on output transfer; reset flushes.
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
    end else begin
      if (a_out_valid && out_ready) begin
        checks++;
        assert (sb.size() > 0) else begin
          failures++;
          $error("[TB] FAIL sb_output_without_input observed=out_valid expected=no_output");
        end
        if (sb.size() > 0) begin
          head = sb.pop_front();
          checkOutput("sb_re_a", 64'(a_re), head.re_a);
          checkOutput("sb_im_a", 64'(a_im), head.im_a);
          checkOutput("sb_ovf_a", 64'(a_ovf), 64'(head.ovf_a));
          checkOutput("sb_valid_t", 64'(t_out_valid), 64'(1));
          checkOutput("sb_re_t", 64'(t_re), head.re_t);
          checkOutput("sb_im_t", 64'(t_im), head.im_t);
          checkOutput("sb_ovf_t", 64'(t_ovf), 64'(head.ovf_t));
          checkOutput("sb_valid_s", 64'(s_out_valid), 64'(1));
          checkOutput("sb_re_s", 64'(s_re), head.re_s);
          checkOutput("sb_im_s", 64'(s_im), head.im_s);
          checkOutput("sb_ovf_s", 64'(s_ovf), 64'(head.ovf_s));
        end
      end
      if (in_valid && a_in_ready) begin
        sb.push_back(predict(in_re, in_im, shift_amt, shift_dir));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one sample and hold it until accepted (bounded), then drop in_valid.
  task automatic applyStimulus(input logic signed [15:0] re, input logic signed [15:0] im,
                               input logic [3:0] amt, input logic dir);
    logic accepted;
    accepted  = 1'b0;
    in_re     = re;
    in_im     = im;
    shift_amt = amt;
    shift_dir = dir;
    in_valid  = 1'b1;
    for (int n = 0; n < 50 && !accepted; n++) begin
      #1;
      accepted = a_in_ready;
      tick();
    end
    checkOutput("in_accepted", 64'(accepted), 64'(1));
    in_valid = 1'b0;
  endtask

  logic signed [15:0] st_re [6];
  logic signed [15:0] st_im [6];
  logic        [3:0]  st_amt[6];
  logic               st_dir[6];
  exp_t               st1;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int  acc_n, emit_n;
    bit  saw_low, acc, emit;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; ovf_clr = 1'b0;
    in_re = '0; in_im = '0; shift_amt = '0; shift_dir = 1'b0;
    tick(); tick();
    checkOutput("rst_out_valid", 64'(a_out_valid), 64'(0));
    checkOutput("rst_in_ready", 64'(a_in_ready), 64'(1));
    checkOutput("rst_out_re", 64'(a_re), 64'(0));
    checkOutput("rst_out_im", 64'(a_im), 64'(0));
    checkOutput("rst_out_ovf", 64'(a_ovf), 64'(0));
    checkOutput("rst_sticky", 64'(a_sticky), 64'(0));
    checkOutput("rst_s_out_re", 64'(s_re), 64'(0));
    rst = 1'b0;
    tick();

    // Left shift by 8 with exact two-cycle latency.
    applyStimulus(16'sh1234, 16'shFFFF, 4'd8, SHIFT_LEFT);
    checkOutput("lat_not_yet", 64'(a_out_valid), 64'(0));
    tick();
    checkOutput("lat_valid", 64'(a_out_valid), 64'(1));
    checkOutput("left8_re", 64'(a_re), 64'(32'sh00123400));
    checkOutput("left8_im", 64'(a_im), 64'(32'shFFFFFF00));
    checkOutput("left8_ovf", 64'(a_ovf), 64'(0));
    tick();

    // Right shift by 4: rounding and truncating instances side by side.
    applyStimulus(16'sh0018, 16'shFFE8, 4'd4, SHIFT_RIGHT);
    tick();
    checkOutput("rnd_re", 64'(a_re), 64'(2));
    checkOutput("rnd_im", 64'(a_im), -64'sd1);
    checkOutput("trunc_re", 64'(t_re), 64'(1));
    checkOutput("trunc_im", 64'(t_im), -64'sd2);
    tick();

    // Narrow instance saturation and sticky flag.
    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
    checkOutput("sticky_cleared", 64'(s_sticky), 64'(0));
    applyStimulus(16'sh1000, 16'sh0000, 4'd4, SHIFT_LEFT);
    tick();
    checkOutput("sat_pos_re", 64'(s_re), 64'(32767));
    checkOutput("sat_pos_ovf", 64'(s_ovf), 64'(1));
    checkOutput("sat_wide_no_ovf", 64'(a_ovf), 64'(0));
    checkOutput("sticky_not_yet", 64'(s_sticky), 64'(0));
    tick();
    checkOutput("sticky_set", 64'(s_sticky), 64'(1));
    applyStimulus(16'sh8000, 16'sh0001, 4'd1, SHIFT_LEFT);
    tick();
    checkOutput("sat_neg_re", 64'(s_re), -64'sd32768);
    checkOutput("sat_neg_ovf", 64'(s_ovf), 64'(1));
    checkOutput("sat_neg_im", 64'(s_im), 64'(2));
    tick();

    // Streaming six samples with a three-cycle downstream stall.
    st_re  = '{16'sh0123, 16'sh7FFF, 16'sh4000, 16'shFFFF, 16'sh0F0F, 16'sh0001};
    st_im  = '{16'shFF00, 16'sh8000, 16'sh0001, 16'sh0003, 16'shF0F0, 16'shFFFF};
    st_amt = '{4'd3, 4'd2, 4'd1, 4'd1, 4'd15, 4'd15};
    st_dir = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    st1 = predict(st_re[1], st_im[1], st_amt[1], st_dir[1]);
    acc_n = 0; emit_n = 0; saw_low = 1'b0;
    in_re = st_re[0]; in_im = st_im[0]; shift_amt = st_amt[0]; shift_dir = st_dir[0];
    in_valid = 1'b1;
    for (int c = 0; c < 30; c++) begin
      out_ready = !(c >= 3 && c <= 5);
      #1;
      if (c >= 3 && c <= 5) begin
        checkOutput("stall_valid", 64'(a_out_valid), 64'(1));
        checkOutput("stall_hold_re", 64'(a_re), st1.re_a);
      end
      if (!a_in_ready) begin
        saw_low = 1'b1;
        checkOutput("held_when_blocked", 64'(acc_n - emit_n), 64'(2));
      end
      acc  = in_valid && a_in_ready;
      emit = a_out_valid && out_ready;
      tick();
      if (emit) emit_n++;
      if (acc) begin
        acc_n++;
        if (acc_n < 6) begin
          in_re = st_re[acc_n]; in_im = st_im[acc_n];
          shift_amt = st_amt[acc_n]; shift_dir = st_dir[acc_n];
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    checkOutput("stream_accepted", 64'(acc_n), 64'(6));
    checkOutput("stream_emitted", 64'(emit_n), 64'(6));
    checkOutput("in_ready_dropped", 64'(saw_low), 64'(1));

    // Reset with two samples in flight.
    out_ready = 1'b0;
    applyStimulus(16'sh0100, 16'sh0200, 4'd1, SHIFT_LEFT);
    applyStimulus(16'sh0300, 16'sh0400, 4'd1, SHIFT_LEFT);
    rst = 1'b1;
    #1;
    checkOutput("rst_async_valid", 64'(a_out_valid), 64'(0));
    checkOutput("rst_async_ready", 64'(a_in_ready), 64'(1));
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      checkOutput("no_stale_output", 64'(a_out_valid), 64'(0));
    end
    applyStimulus(16'sh0055, 16'shFFAA, 4'd2, SHIFT_LEFT);
    checkOutput("post_rst_lat1", 64'(a_out_valid), 64'(0));
    tick();
    checkOutput("post_rst_lat2", 64'(a_out_valid), 64'(1));
    checkOutput("post_rst_re", 64'(a_re), 64'(340));
    tick();

    // Set beats clear in the same cycle; clear alone afterwards.
    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
    checkOutput("sticky_pre_clear", 64'(s_sticky), 64'(0));
    applyStimulus(16'sh1000, 16'sh0000, 4'd4, SHIFT_LEFT);
    tick();
    checkOutput("clr_race_ovf", 64'(s_ovf), 64'(1));
    ovf_clr = 1'b1;
    tick();
    checkOutput("set_wins_clear", 64'(s_sticky), 64'(1));
    tick();
    checkOutput("clear_alone", 64'(s_sticky), 64'(0));
    ovf_clr = 1'b0;

    tick(); tick();
    checkOutput("sb_drained", 64'(sb.size()), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
